mesm6_alu_ctl: RTL and testbench
================================

// Module: mesm6_alu_ctl
// PURPOSE
//  Issue/retire controller directly upstream of the mesm6 ALU. Accepts one arithmetic request at a
//  time from the instruction sequencer (valid/ready) and owns the architectural accumulator (A).
//  Drives the ALU op/operands and waits for its done flag, then retires the result into A.
//  Returns the ALU to NOP between operations and computes the omega condition flag.
// PARAMETERS
//  TIMEOUT   128   max cycles in EXEC waiting for alu_done before abort (>=64)
// PORTS
//  clk          in   1              system clock, all state on rising edge
//  reset_n      in   1              asynchronous, active-low reset
//  req_valid    in   1              request present
//  req_ready    out  1              controller can accept (IDLE only)
//  req_op       in   `ALU_OP_WIDTH  ALU opcode (`ALU_* from mesm6_defines.sv)
//  req_operand  in   48             memory operand (ALU B input, or load value)
//  req_grp      in   2              result group: 00 logical, 01 additive, 10 multiplicative, 11 = keep omega
//  req_wy       in   1              NOP requests only: pulse Y := A
//  req_load     in   1              NOP requests only: A := req_operand
//  rmode_nonorm in   1              mode reg: normalization disabled
//  rmode_noround in  1              mode reg: rounding disabled
//  flush        in   1              abort current op (sync)
//  alu_op       out  `ALU_OP_WIDTH  to ALU op
//  alu_wy       out  1              to ALU wy
//  alu_grp_log  out  1              to ALU grp_log
//  alu_do_norm  out  1              to ALU do_norm
//  alu_do_round out  1              to ALU do_round
//  alu_a        out  48             to ALU a (= acc_q)
//  alu_b        out  48             to ALU b (latched operand)
//  alu_acc      in   48             ALU result
//  alu_done     in   1              ALU registered done flag
//  acc_q        out  48             architectural accumulator
//  omega        out  1              condition flag
//  resp_valid   out  1              1-cycle pulse: op retired, acc_q/omega updated
//  err_timeout  out  1              sticky: op aborted by watchdog; cleared by next accept
// BEHAVIOUR
//  Reset: state IDLE, acc_q=0, alu_b=0, omega=0, alu_op=`ALU_NOP, alu_wy=0, alu_grp_log=0,
//   alu_do_norm=0, alu_do_round=0, resp_valid=0, err_timeout=0, wdog=0. All outputs registered; alu_a=acc_q.
//  req_ready = (state==IDLE). Accept = req_valid & req_ready at edge T.
//  IDLE, accept, req_op==`ALU_NOP (local op): in T+1 alu_wy=req_wy with alu_a = old acc_q, alu_op stays NOP;
//   at end of T+1 acc_q<=req_operand if req_load; resp_valid=1 in T+2, omega unchanged; state stays IDLE
//   but req_ready=0 during T+1 (LOCAL state, 1 cycle).
//  IDLE, accept, other op -> EXEC: from T+1 hold alu_op=req_op, alu_b=req_operand, alu_grp_log=(req_grp==00),
//   alu_do_norm=~rmode_nonorm, alu_do_round=~rmode_noround (mode sampled at accept); wdog cleared.
//  EXEC: wdog++ each cycle. alu_done=1 -> acc_q<=alu_acc, omega update, alu_op<=NOP, -> RELEASE.
//   wdog==TIMEOUT-1 without done -> alu_op<=NOP, err_timeout<=1, acc_q unchanged, -> RELEASE.
//  RELEASE: exactly 1 cycle with alu_op=NOP (clears ALU done/state); resp_valid=1 this cycle; -> IDLE.
//   Min accept-to-accept spacing for an ALU op = ALU latency + 2 cycles.
//  Omega (on done only): 00: omega=(alu_acc!=0); 01: omega=alu_acc[40]; 10: omega=alu_acc[47]; 11: unchanged.
//  alu_done ignored outside EXEC. Done and timeout in same cycle: done wins, no error.
//  flush in EXEC: alu_op<=NOP, acc_q/omega unchanged, -> RELEASE, no resp_valid in RELEASE.
//   flush in IDLE/RELEASE: ignored; flush has priority over req_valid in IDLE (no accept).
//  reset_n low mid-op: immediate return to reset values; the ALU sees NOP next edge.
// TESTING
//  NOP load: req_op=NOP,req_load=1,operand=48'h123 -> acc_q=48'h123 at T+2, resp_valid at T+2, alu_op never non-NOP.
//  AND: acc_q=48'hFF00, operand=48'h0FF0, grp=00, ALU model done after 1 cycle -> acc_q=48'h0F00, omega=1, op NOP 1 cycle.
//  Additive: ALU model returns 48'h0000_0100_0000_0000 (bit40=1), grp=01 -> omega=1; rmode_nonorm=1 -> alu_do_norm=0.
//  Timeout: TIMEOUT=64, ALU model never asserts done -> after 64 EXEC cycles err_timeout=1, acc_q unchanged, back to IDLE.
//  Flush in EXEC cycle 3 of 5-cycle op -> no resp_valid, acc_q unchanged, next request accepted 2 cycles later.
//  Back-to-back: req_valid held high for 3 ops -> req_ready only in IDLE, alu_op=NOP >=1 cycle between ops.

Source files
------------

// File: rtl/mesm6_alu_ctl.sv
// Issue/retire controller between the instruction sequencer and the mesm6 ALU; owns accumulator A and omega.
// Latency: NOP/load retires 2 cycles after accept; ALU ops retire 1 cycle after alu_done (or watchdog/flush).
// Backpressure: req_ready only in IDLE, so one request is in flight at a time; there is no response backpressure.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_NOP
`define ALU_NOP 4'h0
`endif

module mesm6_alu_ctl #(
    parameter int TIMEOUT = 128
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`ALU_OP_WIDTH-1:0] req_op,
    input  logic [47:0]              req_operand,
    input  logic [1:0]               req_grp,
    input  logic                     req_wy,
    input  logic                     req_load,
    input  logic                     rmode_nonorm,
    input  logic                     rmode_noround,
    input  logic                     flush,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic                     alu_wy,
    output logic                     alu_grp_log,
    output logic                     alu_do_norm,
    output logic                     alu_do_round,
    output logic [47:0]              alu_a,
    output logic [47:0]              alu_b,
    input  logic [47:0]              alu_acc,
    input  logic                     alu_done,
    output logic [47:0]              acc_q,
    output logic                     omega,
    output logic                     resp_valid,
    output logic                     err_timeout
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCAL,
        S_EXEC,
        S_RELEASE
    } state_t;

    state_t         state;
    logic [WDW-1:0] wdog;
    logic [1:0]     grp;
    logic           load_pend;

    assign req_ready = (state == S_IDLE);
    assign alu_a     = acc_q;

    function automatic logic omega_next(input logic [1:0] g, input logic [47:0] r, input logic cur);
        case (g)
            2'b00:   return |r;
            2'b01:   return r[40];
            2'b10:   return r[47];
            default: return cur;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            acc_q        <= '0;
            alu_b        <= '0;
            omega        <= 1'b0;
            alu_op       <= `ALU_NOP;
            alu_wy       <= 1'b0;
            alu_grp_log  <= 1'b0;
            alu_do_norm  <= 1'b0;
            alu_do_round <= 1'b0;
            resp_valid   <= 1'b0;
            err_timeout  <= 1'b0;
            wdog         <= '0;
            grp          <= 2'b00;
            load_pend    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            alu_wy     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // flush blocks acceptance so a request racing an abort is not swallowed
                    if (req_valid && !flush) begin
                        err_timeout <= 1'b0;
                        alu_b       <= req_operand;
                        grp         <= req_grp;
                        if (req_op == `ALU_NOP) begin
                            alu_wy    <= req_wy;
                            load_pend <= req_load;
                            state     <= S_LOCAL;
                        end else begin
                            alu_op       <= req_op;
                            alu_grp_log  <= (req_grp == 2'b00);
                            alu_do_norm  <= ~rmode_nonorm;
                            alu_do_round <= ~rmode_noround;
                            wdog         <= '0;
                            state        <= S_EXEC;
                        end
                    end
                end
                S_LOCAL: begin
                    if (load_pend)
                        acc_q <= alu_b;
                    resp_valid <= 1'b1;
                    state      <= S_IDLE;
                end
                S_EXEC: begin
                    wdog <= wdog + 1'b1;
                    if (flush) begin
                        alu_op <= `ALU_NOP;
                        state  <= S_RELEASE;
                    end else if (alu_done) begin
                        acc_q      <= alu_acc;
                        omega      <= omega_next(grp, alu_acc, omega);
                        alu_op     <= `ALU_NOP;
                        resp_valid <= 1'b1;
                        state      <= S_RELEASE;
                    end else if (wdog == WDOG_LAST) begin
                        alu_op      <= `ALU_NOP;
                        err_timeout <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                // one NOP cycle lets the ALU drop done before the next op is issued
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// Bench for mesm6_alu_ctl: vector table, directed corner sequences and random ops against a reference model.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_NOP
`define ALU_NOP 4'h0
`endif
`ifndef ALU_AND
`define ALU_AND 4'h1
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'h2
`endif
`ifndef ALU_MUL
`define ALU_MUL 4'h3
`endif

module tb_mesm6_alu_ctl;

    localparam int TMO = 64;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     req_valid;
    logic                     req_ready;
    logic [`ALU_OP_WIDTH-1:0] req_op;
    logic [47:0]              req_operand;
    logic [1:0]               req_grp;
    logic                     req_wy;
    logic                     req_load;
    logic                     rmode_nonorm;
    logic                     rmode_noround;
    logic                     flush;
    logic [`ALU_OP_WIDTH-1:0] alu_op;
    logic                     alu_wy;
    logic                     alu_grp_log;
    logic                     alu_do_norm;
    logic                     alu_do_round;
    logic [47:0]              alu_a;
    logic [47:0]              alu_b;
    logic [47:0]              alu_acc;
    logic                     alu_done;
    logic [47:0]              acc_q;
    logic                     omega;
    logic                     resp_valid;
    logic                     err_timeout;

    always #5 clk = ~clk;

    mesm6_alu_ctl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_operand(req_operand), .req_grp(req_grp), .req_wy(req_wy),
        .req_load(req_load), .rmode_nonorm(rmode_nonorm), .rmode_noround(rmode_noround),
        .flush(flush), .alu_op(alu_op), .alu_wy(alu_wy), .alu_grp_log(alu_grp_log),
        .alu_do_norm(alu_do_norm), .alu_do_round(alu_do_round), .alu_a(alu_a), .alu_b(alu_b),
        .alu_acc(alu_acc), .alu_done(alu_done), .acc_q(acc_q), .omega(omega),
        .resp_valid(resp_valid), .err_timeout(err_timeout)
    );

    function automatic logic [47:0] alu_fn(input logic [`ALU_OP_WIDTH-1:0] op, input logic [47:0] a, input logic [47:0] b);
        case (op)
            `ALU_AND: return a & b;
            `ALU_ADD: return a + b;
            `ALU_MUL: return a * b;
            default:  return b;
        endcase
    endfunction

    // ALU stand-in: done rises cfg_lat cycles after it first sees a non-NOP op, clears on NOP.
    int          cfg_lat = 1;
    bit          cfg_never = 1'b0;
    bit          spur_done = 1'b0;
    int          alu_cnt;
    logic        alu_done_m;
    logic [47:0] alu_acc_m;
    assign alu_done = alu_done_m | spur_done;
    assign alu_acc  = alu_acc_m;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_cnt <= 0; alu_done_m <= 1'b0; alu_acc_m <= '0;
        end else if (alu_op == `ALU_NOP) begin
            alu_cnt <= 0; alu_done_m <= 1'b0;
        end else begin
            alu_cnt <= alu_cnt + 1;
            if (!cfg_never && alu_cnt + 1 >= cfg_lat) begin
                alu_done_m <= 1'b1;
                alu_acc_m  <= alu_fn(alu_op, alu_a, alu_b);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [47:0] m_acc = '0;
    bit          m_omega = 1'b0;
    bit          m_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One request end to end; expectations come from the reference model (m_*).
    task automatic do_op(input logic [`ALU_OP_WIDTH-1:0] op, input logic [47:0] opnd, input logic [1:0] grp,
                         input bit wy, input bit load, input bit nonorm, input bit noround,
                         input int lat, input bit never);
        int k;
        int exp_k;
        int nop_viol;
        bit timed;
        logic [47:0] old_acc;
        logic [47:0] res;
        k = 0;
        while (!req_ready && k < 200) begin tick; k++; end
        chk("wait_ready", 64'(req_ready), 64'(1));
        cfg_lat = lat; cfg_never = never;
        req_op = op; req_operand = opnd; req_grp = grp; req_wy = wy; req_load = load;
        rmode_nonorm = nonorm; rmode_noround = noround; req_valid = 1'b1;
        old_acc = m_acc;
        m_err = 1'b0;
        if (op == `ALU_NOP) begin
            exp_k = 2;
            if (load) m_acc = opnd;
        end else begin
            timed = never || (lat + 1 > TMO);
            exp_k = timed ? TMO + 1 : lat + 2;
            m_err = timed;
            if (!timed) begin
                res = alu_fn(op, m_acc, opnd);
                m_acc = res;
                if (grp == 2'd0) m_omega = (res != 48'd0);
                else if (grp == 2'd1) m_omega = res[40];
                else if (grp == 2'd2) m_omega = res[47];
            end
        end
        tick;
        req_valid = 1'b0;
        k = 1;
        chk("busy_ready", 64'(req_ready), 64'(0));
        if (op == `ALU_NOP) begin
            chk("nop_wy", 64'(alu_wy), 64'(wy));
            chk("nop_alu_a", 64'(alu_a), 64'(old_acc));
        end else begin
            chk("exec_op", 64'(alu_op), 64'(op));
            chk("exec_b", 64'(alu_b), 64'(opnd));
            chk("exec_grp_log", 64'(alu_grp_log), 64'(grp == 2'd0));
            chk("exec_norm", 64'(alu_do_norm), 64'(!nonorm));
            chk("exec_round", 64'(alu_do_round), 64'(!noround));
        end
        nop_viol = 0;
        while (!resp_valid && k < 300) begin
            if (op == `ALU_NOP && alu_op != `ALU_NOP) nop_viol++;
            tick; k++;
        end
        chk("resp_latency", 64'(k), 64'(exp_k));
        chk("acc_q", 64'(acc_q), 64'(m_acc));
        chk("omega", 64'(omega), 64'(m_omega));
        chk("err_timeout", 64'(err_timeout), 64'(m_err));
        chk("op_nop_at_resp", 64'(alu_op), 64'(`ALU_NOP));
        if (op == `ALU_NOP) chk("nop_no_alu_op", 64'(nop_viol), 64'(0));
        tick;
        chk("resp_pulse", 64'(resp_valid), 64'(0));
    endtask

    typedef struct {
        logic [`ALU_OP_WIDTH-1:0] op;
        logic [47:0] opnd;
        logic [1:0]  grp;
        bit wy; bit load; bit nonorm; bit noround;
        int lat;
        logic [47:0] e_acc;
        bit e_omega; bit e_norm; bit e_round;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int viol;
        int acc_n;
        int rsp_n;
        logic [`ALU_OP_WIDTH-1:0] ops[4];
        ops[0] = `ALU_NOP; ops[1] = `ALU_AND; ops[2] = `ALU_ADD; ops[3] = `ALU_MUL;

        tbl[0]  = '{`ALU_NOP, 48'h123,            2'd0, 0, 1, 0, 0, 1, 48'h123,            0, 0, 0};
        tbl[1]  = '{`ALU_NOP, 48'hFF00,           2'd0, 0, 1, 0, 0, 1, 48'hFF00,           0, 0, 0};
        tbl[2]  = '{`ALU_AND, 48'h0FF0,           2'd0, 0, 0, 0, 0, 1, 48'h0F00,           1, 1, 1};
        tbl[3]  = '{`ALU_NOP, 48'h0,              2'd0, 0, 1, 0, 0, 1, 48'h0,              1, 0, 0};
        tbl[4]  = '{`ALU_ADD, 48'h0000_0100_0000_0000, 2'd1, 0, 0, 1, 0, 2, 48'h0000_0100_0000_0000, 1, 0, 1};
        tbl[5]  = '{`ALU_AND, 48'h0,              2'd0, 0, 0, 0, 1, 1, 48'h0,              0, 1, 0};
        tbl[6]  = '{`ALU_NOP, 48'h8000_0000_0001, 2'd0, 0, 1, 0, 0, 1, 48'h8000_0000_0001, 0, 0, 0};
        tbl[7]  = '{`ALU_MUL, 48'h1,              2'd2, 0, 0, 0, 0, 3, 48'h8000_0000_0001, 1, 1, 1};
        tbl[8]  = '{`ALU_ADD, 48'h7FFF_FFFF_FFFF, 2'd3, 0, 0, 0, 0, 1, 48'h0,              1, 1, 1};
        tbl[9]  = '{`ALU_ADD, 48'hFFFF_FFFF_FFFF, 2'd1, 0, 0, 0, 0, 4, 48'hFFFF_FFFF_FFFF, 1, 1, 1};
        tbl[10] = '{`ALU_NOP, 48'h55,             2'd0, 1, 0, 0, 0, 1, 48'hFFFF_FFFF_FFFF, 1, 0, 0};

        reset_n = 1'b0; req_valid = 1'b0; req_op = `ALU_NOP; req_operand = '0; req_grp = '0;
        req_wy = 1'b0; req_load = 1'b0; rmode_nonorm = 1'b0; rmode_noround = 1'b0; flush = 1'b0;
        repeat (3) tick;
        reset_n = 1'b1;
        tick;
        chk("rst_acc", 64'(acc_q), 64'(0));
        chk("rst_b", 64'(alu_b), 64'(0));
        chk("rst_omega", 64'(omega), 64'(0));
        chk("rst_op", 64'(alu_op), 64'(`ALU_NOP));
        chk("rst_flags", 64'({alu_wy, alu_grp_log, alu_do_norm, alu_do_round}), 64'(0));
        chk("rst_resp_err", 64'({resp_valid, err_timeout}), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].op, tbl[i].opnd, tbl[i].grp, tbl[i].wy, tbl[i].load,
                  tbl[i].nonorm, tbl[i].noround, tbl[i].lat, 1'b0);
            chk($sformatf("vec%0d_acc", i), 64'(acc_q), 64'(tbl[i].e_acc));
            chk($sformatf("vec%0d_omega", i), 64'(omega), 64'(tbl[i].e_omega));
            if (tbl[i].op != `ALU_NOP)
                chk($sformatf("vec%0d_mode", i), 64'({alu_do_norm, alu_do_round}),
                    64'({tbl[i].e_norm, tbl[i].e_round}));
        end

        // watchdog: never done, done on the last allowed cycle, and one cycle too late
        do_op(`ALU_ADD, 48'h5, 2'd0, 0, 0, 0, 0, 1, 1'b1);
        chk("tmo_ready", 64'(req_ready), 64'(1));
        do_op(`ALU_NOP, 48'h0, 2'd0, 0, 0, 0, 0, 1, 1'b0);
        do_op(`ALU_ADD, 48'h1, 2'd1, 0, 0, 0, 0, TMO - 1, 1'b0);
        do_op(`ALU_ADD, 48'h1, 2'd1, 0, 0, 0, 0, TMO, 1'b0);

        // flush in EXEC cycle 3 of a 5-cycle op, next request accepted 2 cycles after flush
        cfg_lat = 5; cfg_never = 1'b0;
        req_op = `ALU_AND; req_operand = 48'h0; req_grp = 2'd0; req_valid = 1'b1;
        tick; req_valid = 1'b0;
        viol = 0;
        tick; if (resp_valid) viol++;
        tick; flush = 1'b1; if (resp_valid) viol++;
        tick; flush = 1'b0;
        chk("flush_rel_op", 64'(alu_op), 64'(`ALU_NOP));
        chk("flush_rel_ready", 64'(req_ready), 64'(0));
        if (resp_valid) viol++;
        req_op = `ALU_NOP; req_load = 1'b1; req_operand = 48'h5A5; req_valid = 1'b1;
        tick;
        if (resp_valid) viol++;
        chk("flush_no_resp", 64'(viol), 64'(0));
        chk("flush_acc", 64'(acc_q), 64'(m_acc));
        chk("flush_omega", 64'(omega), 64'(m_omega));
        chk("flush_idle_ready", 64'(req_ready), 64'(1));
        tick; req_valid = 1'b0;
        chk("flush_accepted", 64'(req_ready), 64'(0));
        tick;
        m_acc = 48'h5A5; m_err = 1'b0;
        chk("flush_next_resp", 64'(resp_valid), 64'(1));
        chk("flush_next_acc", 64'(acc_q), 64'(m_acc));
        tick;

        // flush beats req_valid in IDLE
        flush = 1'b1; req_valid = 1'b1; req_op = `ALU_NOP; req_load = 1'b1; req_operand = 48'h777;
        tick; flush = 1'b0;
        chk("idle_flush_ready", 64'(req_ready), 64'(1));
        tick; req_valid = 1'b0;
        chk("idle_flush_later_accept", 64'(req_ready), 64'(0));
        tick;
        m_acc = 48'h777;
        chk("idle_flush_acc", 64'(acc_q), 64'(m_acc));
        tick;

        // alu_done outside EXEC must be ignored
        spur_done = 1'b1;
        viol = 0;
        repeat (3) begin tick; if (resp_valid || acc_q != m_acc || !req_ready) viol++; end
        spur_done = 1'b0;
        chk("spurious_done", 64'(viol), 64'(0));
        tick;

        // back-to-back with req_valid held high for 3 ADD+1 ops
        cfg_lat = 2; cfg_never = 1'b0;
        req_op = `ALU_ADD; req_operand = 48'h1; req_grp = 2'd3; req_load = 1'b0; req_valid = 1'b1;
        acc_n = 0; rsp_n = 0; viol = 0;
        for (int c = 0; c < 60 && rsp_n < 3; c++) begin
            if (resp_valid) rsp_n++;
            if (req_ready && alu_op != `ALU_NOP) viol++;
            if (alu_op != `ALU_NOP && req_ready) viol++;
            if (req_ready && req_valid) acc_n++;
            tick;
            if (acc_n == 3) req_valid = 1'b0;
        end
        m_acc = m_acc + 48'd3;
        chk("b2b_accepts", 64'(acc_n), 64'(3));
        chk("b2b_resps", 64'(rsp_n), 64'(3));
        chk("b2b_ready_only_idle", 64'(viol), 64'(0));
        chk("b2b_acc", 64'(acc_q), 64'(m_acc));
        tick; tick;

        // randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            logic [`ALU_OP_WIDTH-1:0] rop;
            rop = ops[$urandom_range(0, 3)];
            do_op(rop, {16'($urandom()), $urandom()}, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 8), ($urandom_range(0, 15) == 0) && (rop != `ALU_NOP));
        end

        // reset in the middle of an op
        cfg_lat = 5;
        req_op = `ALU_MUL; req_operand = 48'h3; req_grp = 2'd0; req_valid = 1'b1;
        tick; req_valid = 1'b0;
        tick;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_op", 64'(alu_op), 64'(`ALU_NOP));
        chk("midrst_acc", 64'(acc_q), 64'(0));
        chk("midrst_ready", 64'(req_ready), 64'(1));
        chk("midrst_flags", 64'({omega, err_timeout, resp_valid}), 64'(0));
        tick; reset_n = 1'b1;
        m_acc = '0; m_omega = 1'b0; m_err = 1'b0;
        tick;
        do_op(`ALU_AND, 48'hFFFF, 2'd0, 0, 0, 0, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
